// File: rtl/comm_pkg.sv
// rtl/comm_pkg.sv - shared constants and types for the host-side command master
//
// Holds the default bit period, the 8N1 frame length and the command FSM
// state encoding used by comm_master and comm_uart.

package comm_pkg;

  // Clocks per UART bit: 19200 baud from a 50 MHz clock.
  localparam int BAUD_DIV_DEFAULT = 2604;

  // Start + 8 data + stop.
  localparam int FRAME_BITS = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_HI = 2'd1,
    SEND_LO = 2'd2
  } cmd_state_e;

endpackage

// File: rtl/comm_uart.sv
// rtl/comm_uart.sv - 8N1 UART transmitter and receiver sharing one bit period
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   trmt              launch a frame of tx_data (accepted only when tx idle)
//   tx_data[7:0]      byte to transmit
//   tx_done           one-cycle pulse at the end of the stop bit
//   TX                serial out, idle high
//   RX                serial in, idle high (asynchronous to clk)
//   rx_data[7:0]      last correctly framed byte
//   rdy               one-cycle pulse when rx_data is updated

module comm_uart
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       trmt,
  input  logic [7:0] tx_data,
  output logic       tx_done,
  output logic       TX,
  input  logic       RX,
  output logic [7:0] rx_data,
  output logic       rdy
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  // Two clocks of the half period are already spent in edge detection, so
  // the start-bit check lands at the middle of the synchronized bit.
  localparam logic [CW-1:0] BAUD_HALF = CW'(BAUD_DIV / 2 - 2);
  localparam logic [3:0]    STOP_IDX  = 4'(FRAME_BITS - 1);

  // Transmitter state
  logic          tx_busy_q, tx_busy_d;
  logic [CW-1:0] tx_baud_q, tx_baud_d;
  logic [3:0]    tx_bit_q, tx_bit_d;
  logic [8:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;
  logic          tx_done_q, tx_done_d;

  // Receiver state
  logic [1:0]    rx_sync_q, rx_sync_d;
  logic          rx_prev_q, rx_prev_d;
  logic          rx_busy_q, rx_busy_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rdy_q, rdy_d;

  logic          rx_bit_in;
  logic          rx_fall;
  logic [CW-1:0] rx_target;

  assign TX      = tx_line_q;
  assign tx_done = tx_done_q;
  assign rx_data = rx_data_q;
  assign rdy     = rdy_q;

  // Transmitter: the start bit is driven directly on launch, the remaining
  // nine bits ({stop, data}) shift out LSB first at each bit boundary.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = tx_line_q;
    tx_done_d  = 1'b0;
    if (!tx_busy_q) begin
      if (trmt) begin
        tx_busy_d  = 1'b1;
        tx_baud_d  = '0;
        tx_bit_d   = '0;
        tx_shift_d = {1'b1, tx_data};
        tx_line_d  = 1'b0;
      end
    end else if (tx_baud_q == BAUD_LAST) begin
      tx_baud_d = '0;
      if (tx_bit_q == STOP_IDX) begin
        tx_busy_d = 1'b0;
        tx_done_d = 1'b1;
      end else begin
        tx_line_d  = tx_shift_q[0];
        tx_shift_d = {1'b1, tx_shift_q[8:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
      end
    end else begin
      tx_baud_d = tx_baud_q + 1'b1;
    end
  end

  // Receiver: bit 0 is the start-bit recheck at half period, bits 1..8 are
  // data, bit 9 is the stop bit. Going idle right after the stop sample lets
  // the next start edge be caught with zero idle between frames.
  assign rx_bit_in = rx_sync_q[1];
  assign rx_fall   = rx_prev_q & ~rx_bit_in;
  assign rx_target = (rx_bit_q == 4'd0) ? BAUD_HALF : BAUD_LAST;

  always_comb begin
    rx_sync_d  = {rx_sync_q[0], RX};
    rx_prev_d  = rx_bit_in;
    rx_busy_d  = rx_busy_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rdy_d      = 1'b0;
    if (!rx_busy_q) begin
      if (rx_fall) begin
        rx_busy_d = 1'b1;
        rx_baud_d = '0;
        rx_bit_d  = '0;
      end
    end else if (rx_baud_q == rx_target) begin
      rx_baud_d = '0;
      rx_bit_d  = rx_bit_q + 4'd1;
      if (rx_bit_q == 4'd0) begin
        if (rx_bit_in) begin
          rx_busy_d = 1'b0;
        end
      end else if (rx_bit_q == STOP_IDX) begin
        rx_busy_d = 1'b0;
        if (rx_bit_in) begin
          rx_data_d = rx_shift_q;
          rdy_d     = 1'b1;
        end
      end else begin
        rx_shift_d = {rx_bit_in, rx_shift_q[7:1]};
      end
    end else begin
      rx_baud_d = rx_baud_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '1;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b0;
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_busy_q  <= 1'b0;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      rdy_q      <= 1'b0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
      tx_done_q  <= tx_done_d;
      rx_sync_q  <= rx_sync_d;
      rx_prev_q  <= rx_prev_d;
      rx_busy_q  <= rx_busy_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      rdy_q      <= rdy_d;
    end
  end

endmodule

// File: rtl/comm_master.sv
// rtl/comm_master.sv - host-side command master: 16-bit command out as two UART bytes, response bytes in
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   snd_cmd           start a command; only looked at while idle
//   cmd[15:0]         command word, high byte sent first
//   TX                serial out, idle high
//   RX                serial in, idle high
//   cmd_cmplt         level, set once both bytes are sent, cleared on next accept
//   resp[7:0]         last received response byte
//   resp_cmplt        one-cycle pulse when resp is updated

module comm_master
  import comm_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        snd_cmd,
  input  logic [15:0] cmd,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_cmplt,
  output logic [7:0]  resp,
  output logic        resp_cmplt
);

  cmd_state_e state_q, state_d;
  logic [7:0] lo_byte_q, lo_byte_d;
  logic       cmd_cmplt_q, cmd_cmplt_d;
  logic [7:0] resp_q, resp_d;
  logic       resp_cmplt_q, resp_cmplt_d;

  logic       trmt;
  logic [7:0] tx_data;
  logic       tx_done;
  logic [7:0] rx_data;
  logic       rdy;

  comm_uart #(
    .BAUD_DIV (BAUD_DIV)
  ) u_uart (
    .clk     (clk),
    .rst_n   (rst_n),
    .trmt    (trmt),
    .tx_data (tx_data),
    .tx_done (tx_done),
    .TX      (TX),
    .RX      (RX),
    .rx_data (rx_data),
    .rdy     (rdy)
  );

  assign cmd_cmplt  = cmd_cmplt_q;
  assign resp       = resp_q;
  assign resp_cmplt = resp_cmplt_q;

  // The high byte goes straight from cmd on the accepting cycle; the low byte
  // is captured then so cmd is free to change during transmission.
  always_comb begin
    state_d     = state_q;
    lo_byte_d   = lo_byte_q;
    cmd_cmplt_d = cmd_cmplt_q;
    trmt        = 1'b0;
    tx_data     = cmd[15:8];
    case (state_q)
      IDLE: begin
        if (snd_cmd) begin
          lo_byte_d   = cmd[7:0];
          trmt        = 1'b1;
          tx_data     = cmd[15:8];
          cmd_cmplt_d = 1'b0;
          state_d     = SEND_HI;
        end
      end
      SEND_HI: begin
        if (tx_done) begin
          trmt    = 1'b1;
          tx_data = lo_byte_q;
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        if (tx_done) begin
          cmd_cmplt_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    resp_d       = rdy ? rx_data : resp_q;
    resp_cmplt_d = rdy;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      lo_byte_q    <= '0;
      cmd_cmplt_q  <= 1'b0;
      resp_q       <= '0;
      resp_cmplt_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lo_byte_q    <= lo_byte_d;
      cmd_cmplt_q  <= cmd_cmplt_d;
      resp_q       <= resp_d;
      resp_cmplt_q <= resp_cmplt_d;
    end
  end

endmodule

// File: tb/tb_comm_master.sv
// tb/tb_comm_master.sv - scoreboard bench for comm_master

module tb_comm_master;

  localparam int B = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        snd_cmd = 1'b0;
  logic [15:0] cmd = 16'h0000;
  logic        RX = 1'b1;
  logic        TX;
  logic        cmd_cmplt;
  logic [7:0]  resp;
  logic        resp_cmplt;

  always #5 clk = ~clk;

  comm_master #(
    .BAUD_DIV (B)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .snd_cmd    (snd_cmd),
    .cmd        (cmd),
    .TX         (TX),
    .RX         (RX),
    .cmd_cmplt  (cmd_cmplt),
    .resp       (resp),
    .resp_cmplt (resp_cmplt)
  );

  int n_checks = 0;
  int n_errors = 0;
  int tx_frames = 0;
  int rsp_count = 0;
  bit tx_abort = 1'b0;
  logic [7:0] exp_tx_q[$];
  logic [7:0] exp_rsp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Peer receiver decoding TX
  initial begin : tx_mon
    logic [7:0] b;
    logic st;
    logic sp;
    forever begin
      @(negedge TX);
      repeat (B / 2) @(negedge clk);
      st = TX;
      for (int i = 0; i < 8; i++) begin
        repeat (B) @(negedge clk);
        b[i] = TX;
      end
      repeat (B) @(negedge clk);
      sp = TX;
      if (tx_abort) begin
        tx_abort = 1'b0;
      end else begin
        tx_frames++;
        check("tx_start_bit", st, 1'b0);
        check("tx_stop_bit", sp, 1'b1);
        if (exp_tx_q.size() == 0) check("tx_extra_frame", 1, 0);
        else check("tx_byte", b, exp_tx_q.pop_front());
      end
    end
  end

  // Response strobe watcher
  initial begin : rsp_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_cmplt === 1'b1) begin
        check("resp_pulse_width", prev, 1'b0);
        rsp_count++;
        if (exp_rsp_q.size() == 0) check("resp_unexpected", 1, 0);
        else check("resp_byte", resp, exp_rsp_q.pop_front());
      end
      prev = resp_cmplt;
    end
  end

  // Peer transmitter driving RX; called on a negedge
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    if (stop_bit) exp_rsp_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      repeat (B) @(negedge clk);
    end
  endtask

  task automatic do_cmd(input logic [15:0] c);
    int n;
    bit seen;
    @(negedge clk);
    exp_tx_q.push_back(c[15:8]);
    exp_tx_q.push_back(c[7:0]);
    cmd = c;
    snd_cmd = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 20 * B + 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        check("cmplt_cleared", cmd_cmplt, 1'b0);
        cmd = ~c;
      end
      if (n == 2) snd_cmd = 1'b0;
      if (cmd_cmplt === 1'b1) seen = 1'b1;
    end
    snd_cmd = 1'b0;
    check("cmplt_seen", seen, 1'b1);
    if (seen) check("cmplt_latency", n - 1, 20 * B + 2);
  endtask

  initial begin : main
    int f0;
    int r0;
    repeat (3) @(negedge clk);
    check("rst_TX", TX, 1'b1);
    check("rst_cmd_cmplt", cmd_cmplt, 1'b0);
    check("rst_resp", resp, 8'h00);
    check("rst_resp_cmplt", resp_cmplt, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic command with a two-clock snd_cmd
    f0 = tx_frames;
    do_cmd(16'h4105);
    repeat (2 * B) @(negedge clk);
    check("t1_frames", tx_frames - f0, 2);
    check("t1_tx_q_empty", exp_tx_q.size(), 0);
    check("t1_cmplt_hold", cmd_cmplt, 1'b1);

    // Single response byte
    r0 = rsp_count;
    send_byte(8'hA5, 1'b1);
    repeat (B) @(negedge clk);
    check("t2_count", rsp_count - r0, 1);
    check("t2_resp", resp, 8'hA5);
    check("t2_cmd_cmplt", cmd_cmplt, 1'b1);

    // Back-to-back stream
    r0 = rsp_count;
    for (int i = 0; i < 384; i++) send_byte(8'((i % 128) + 1), 1'b1);
    repeat (2 * B) @(negedge clk);
    check("t3_count", rsp_count - r0, 384);
    check("t3_rsp_q_empty", exp_rsp_q.size(), 0);

    // Full duplex
    f0 = tx_frames;
    r0 = rsp_count;
    fork
      do_cmd(16'h1234);
      begin
        repeat (3 * B) @(negedge clk);
        send_byte(8'hEE, 1'b1);
      end
    join
    repeat (2 * B) @(negedge clk);
    check("t4_frames", tx_frames - f0, 2);
    check("t4_rsp_count", rsp_count - r0, 1);
    check("t4_resp", resp, 8'hEE);
    check("t4_tx_q_empty", exp_tx_q.size(), 0);

    // Glitch and framing error
    r0 = rsp_count;
    RX = 1'b0;
    repeat (B / 4) @(negedge clk);
    RX = 1'b1;
    repeat (3 * B) @(negedge clk);
    check("t5_glitch_count", rsp_count - r0, 0);
    send_byte(8'h3C, 1'b0);
    RX = 1'b1;
    repeat (3 * B) @(negedge clk);
    check("t5_frame_err_count", rsp_count - r0, 0);
    check("t5_resp_held", resp, 8'hEE);
    send_byte(8'h5A, 1'b1);
    repeat (B) @(negedge clk);
    check("t5_recover", resp, 8'h5A);

    // Reset in the middle of the high byte
    @(negedge clk);
    cmd = 16'hC3A5;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
    repeat (4 * B) @(negedge clk);
    tx_abort = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t6_TX_high", TX, 1'b1);
    check("t6_cmd_cmplt", cmd_cmplt, 1'b0);
    check("t6_resp", resp, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12 * B) @(negedge clk);
    check("t6_partial_frame_seen", tx_abort, 1'b0);
    f0 = tx_frames;
    do_cmd(16'h6E91);
    repeat (2 * B) @(negedge clk);
    check("t6_frames", tx_frames - f0, 2);
    check("t6_tx_q_empty", exp_tx_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
